// File: rtl/vote_judge_pkg.sv
// vote_judge_pkg: state encoding and yes-count width helper shared by the voting judge.
package vote_judge_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTING = 2'd1,
    DONE   = 2'd2
  } state_t;
  function automatic int cw(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/vote_popcount.sv
// vote_popcount: counts judges whose vote is newly accepted this cycle and is yes.
module vote_popcount
  import vote_judge_pkg::*;
#(
  parameter int N_JUDGES = 3
) (
  input  logic [N_JUDGES-1:0]     accept_i,
  input  logic [N_JUDGES-1:0]     vote_i,
  output logic [cw(N_JUDGES)-1:0] cnt_o
);
  localparam int CW = cw(N_JUDGES);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N_JUDGES; i++) cnt_o = cnt_o + CW'(accept_i[i] & vote_i[i]);
  end
endmodule

// File: rtl/vote_judge.sv
// vote_judge: collects one final vote per judge per session and reports a
// thresholded pass after every judge has voted or the session timer expires.
module vote_judge
  import vote_judge_pkg::*;
#(
  parameter int N_JUDGES = 3,
  parameter int THRESH   = (N_JUDGES / 2) + 1,
  parameter int TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_JUDGES-1:0]     vote_en,
  input  logic [N_JUDGES-1:0]     vote,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [cw(N_JUDGES)-1:0] yes_cnt,
  output logic [N_JUDGES-1:0]     voted
);
  localparam int CW = cw(N_JUDGES);
  if (N_JUDGES < 2 || N_JUDGES > 16 || THRESH < 1 || THRESH > N_JUDGES ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $fatal(1, "vote_judge: parameter out of range");
  end
  localparam logic [CW-1:0] THR   = CW'(THRESH);
  localparam logic [7:0]    TLAST = 8'(TIMEOUT - 1);
  state_t              state_q, state_d;
  logic [7:0]          timer_q, timer_d;
  logic [N_JUDGES-1:0] voted_q, voted_d, accept, mask_up;
  logic [CW-1:0]       yes_q, yes_d, add, yes_up;
  logic                pass_q, pass_d;
  // only judges that have not voted yet may contribute, and only while voting
  assign accept  = (state_q == VOTING) ? (vote_en & ~voted_q) : '0;
  assign mask_up = voted_q | accept;
  assign yes_up  = yes_q + add;
  vote_popcount #(.N_JUDGES(N_JUDGES)) u_pop (
    .accept_i(accept),
    .vote_i  (vote),
    .cnt_o   (add)
  );
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    voted_d = voted_q;
    yes_d   = yes_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = VOTING;
        timer_d = '0;
        voted_d = '0;
        yes_d   = '0;
        pass_d  = 1'b0;
      end
      VOTING: begin
        voted_d = mask_up;
        yes_d   = yes_up;
        timer_d = timer_q + 8'd1;
        if (&mask_up || timer_q == TLAST) begin
          state_d = DONE;
          pass_d  = yes_up >= THR;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      voted_q <= '0;
      yes_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      voted_q <= voted_d;
      yes_q   <= yes_d;
      pass_q  <= pass_d;
    end
  end
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign pass    = pass_q;
  assign yes_cnt = yes_q;
  assign voted   = voted_q;
endmodule
